// File: rtl/avalon_mm_addr_conv_reg.sv
// Registered byte-to-word address converter for Avalon-MM with alignment,
// range checking and an optional downstream waitrequest timeout.
module avalon_mm_addr_conv_reg #(
  parameter int ADDR_WIDTH       = 32,
  parameter int OUT_ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_SHIFT       = $clog2(BYTEENABLE_WIDTH),
  parameter int CHECK_ALIGN      = 1,
  parameter int TIMEOUT          = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       avalon_mm_in_address,
  input  logic [BYTEENABLE_WIDTH-1:0] avalon_mm_in_byteenable,
  input  logic                        avalon_mm_in_read,
  input  logic                        avalon_mm_in_write,
  input  logic [DATA_WIDTH-1:0]       avalon_mm_in_writedata,
  output logic [DATA_WIDTH-1:0]       avalon_mm_in_readdata,
  output logic [1:0]                  avalon_mm_in_response,
  output logic                        avalon_mm_in_waitrequest,
  output logic [OUT_ADDR_WIDTH-1:0]   avalon_mm_out_address,
  output logic [BYTEENABLE_WIDTH-1:0] avalon_mm_out_byteenable,
  output logic                        avalon_mm_out_read,
  output logic                        avalon_mm_out_write,
  output logic [DATA_WIDTH-1:0]       avalon_mm_out_writedata,
  input  logic [DATA_WIDTH-1:0]       avalon_mm_out_readdata,
  input  logic [1:0]                  avalon_mm_out_response,
  input  logic                        avalon_mm_out_waitrequest
);

  localparam int AW_MAX = (ADDR_WIDTH > OUT_ADDR_WIDTH) ? ADDR_WIDTH : OUT_ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ADDR_SHIFT) - 64'd1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [OUT_ADDR_WIDTH-1:0]   out_address_q, out_address_d;
  logic [BYTEENABLE_WIDTH-1:0] out_byteenable_q, out_byteenable_d;
  logic [DATA_WIDTH-1:0]       out_writedata_q, out_writedata_d;
  logic                        out_read_q, out_read_d;
  logic                        out_write_q, out_write_d;
  logic [DATA_WIDTH-1:0]       in_readdata_q, in_readdata_d;
  logic [1:0]                  in_response_q, in_response_d;
  logic [15:0]                 tmo_cnt_q, tmo_cnt_d;

  // Word address widened to cover both sides, so any bit at or above
  // OUT_ADDR_WIDTH marks an unreachable target.
  logic [AW_MAX-1:0] word_ext;
  logic              decode_err;
  logic              align_err;

  assign word_ext   = AW_MAX'(avalon_mm_in_address >> ADDR_SHIFT);
  assign decode_err = |(word_ext >> OUT_ADDR_WIDTH);
  assign align_err  = (CHECK_ALIGN != 0) && ((avalon_mm_in_address & ALIGN_MASK) != '0);

  always_comb begin
    state_d          = state_q;
    out_address_d    = out_address_q;
    out_byteenable_d = out_byteenable_q;
    out_writedata_d  = out_writedata_q;
    out_read_d       = out_read_q;
    out_write_d      = out_write_q;
    in_readdata_d    = in_readdata_q;
    in_response_d    = in_response_q;
    tmo_cnt_d        = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (avalon_mm_in_read || avalon_mm_in_write) begin
          if (align_err || (avalon_mm_in_read && avalon_mm_in_write)) begin
            in_readdata_d = '0;
            in_response_d = RESP_SLVERR;
            state_d       = DONE;
          end else if (decode_err) begin
            in_readdata_d = '0;
            in_response_d = RESP_DECERR;
            state_d       = DONE;
          end else begin
            out_address_d    = word_ext[OUT_ADDR_WIDTH-1:0];
            out_byteenable_d = avalon_mm_in_byteenable;
            out_writedata_d  = avalon_mm_in_writedata;
            out_read_d       = avalon_mm_in_read;
            out_write_d      = avalon_mm_in_write;
            tmo_cnt_d        = '0;
            state_d          = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!avalon_mm_out_waitrequest) begin
          in_readdata_d = out_read_q ? avalon_mm_out_readdata : '0;
          in_response_d = avalon_mm_out_response;
          out_read_d    = 1'b0;
          out_write_d   = 1'b0;
          state_d       = DONE;
        end else if (TIMEOUT != 0) begin
          // Timeout fires on the TIMEOUT-th stalled cycle of this access.
          if (({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT)) begin
            in_readdata_d = '0;
            in_response_d = RESP_DECERR;
            out_read_d    = 1'b0;
            out_write_d   = 1'b0;
            state_d       = DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      out_address_q    <= '0;
      out_byteenable_q <= '0;
      out_writedata_q  <= '0;
      out_read_q       <= 1'b0;
      out_write_q      <= 1'b0;
      in_readdata_q    <= '0;
      in_response_q    <= '0;
      tmo_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      out_address_q    <= out_address_d;
      out_byteenable_q <= out_byteenable_d;
      out_writedata_q  <= out_writedata_d;
      out_read_q       <= out_read_d;
      out_write_q      <= out_write_d;
      in_readdata_q    <= in_readdata_d;
      in_response_q    <= in_response_d;
      tmo_cnt_q        <= tmo_cnt_d;
    end
  end

  assign avalon_mm_in_waitrequest = (state_q != DONE);
  assign avalon_mm_in_readdata    = in_readdata_q;
  assign avalon_mm_in_response    = in_response_q;
  assign avalon_mm_out_address    = out_address_q;
  assign avalon_mm_out_byteenable = out_byteenable_q;
  assign avalon_mm_out_writedata  = out_writedata_q;
  assign avalon_mm_out_read       = out_read_q;
  assign avalon_mm_out_write      = out_write_q;

endmodule

// File: tb/tb_avalon_mm_addr_conv_reg.sv
// Scoreboard bench for avalon_mm_addr_conv_reg: 32-bit data, 8-bit word
// address, 16-cycle timeout; upstream and downstream transfers are queued.
module tb_avalon_mm_addr_conv_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_address;
  logic [3:0]  in_byteenable;
  logic        in_read, in_write;
  logic [31:0] in_writedata;
  logic [31:0] in_readdata;
  logic [1:0]  in_response;
  logic        in_waitrequest;
  logic [7:0]  out_address;
  logic [3:0]  out_byteenable;
  logic        out_read, out_write;
  logic [31:0] out_writedata;
  logic [31:0] out_readdata;
  logic [1:0]  out_response;
  logic        out_waitrequest;

  always #5 clk = ~clk;

  avalon_mm_addr_conv_reg #(
    .ADDR_WIDTH(32), .OUT_ADDR_WIDTH(8), .DATA_WIDTH(32),
    .CHECK_ALIGN(1), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avalon_mm_in_address(in_address),
    .avalon_mm_in_byteenable(in_byteenable),
    .avalon_mm_in_read(in_read),
    .avalon_mm_in_write(in_write),
    .avalon_mm_in_writedata(in_writedata),
    .avalon_mm_in_readdata(in_readdata),
    .avalon_mm_in_response(in_response),
    .avalon_mm_in_waitrequest(in_waitrequest),
    .avalon_mm_out_address(out_address),
    .avalon_mm_out_byteenable(out_byteenable),
    .avalon_mm_out_read(out_read),
    .avalon_mm_out_write(out_write),
    .avalon_mm_out_writedata(out_writedata),
    .avalon_mm_out_readdata(out_readdata),
    .avalon_mm_out_response(out_response),
    .avalon_mm_out_waitrequest(out_waitrequest)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Slave model: waits slv_wait cycles per access, or forever when stuck.
  int   slv_wait  = 0;
  int   slv_cnt   = 0;
  logic slv_stuck = 1'b0;
  assign out_waitrequest = slv_stuck || (slv_cnt < slv_wait);

  always @(posedge clk) begin
    if ((out_read || out_write) && out_waitrequest) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end

  typedef struct { logic [31:0] rdata; logic [1:0] resp; } up_t;
  typedef struct { logic [7:0] addr; logic [3:0] be; logic [31:0] wd; logic wr; } dn_t;
  up_t up_q[$];
  dn_t dn_q[$];
  int  oreq_total = 0;

  always @(negedge clk) begin
    if (out_read || out_write) oreq_total <= oreq_total + 1;
  end

  always @(negedge clk) begin
    up_t e;
    if (rst_n && (in_read || in_write) && !in_waitrequest) begin
      if (up_q.size() == 0) chk("up_unexpected", 1, 0);
      else begin
        e = up_q.pop_front();
        chk("up_readdata", in_readdata, e.rdata);
        chk("up_response", in_response, e.resp);
      end
    end
  end

  always @(negedge clk) begin
    dn_t e;
    if (rst_n && (out_read || out_write) && !out_waitrequest) begin
      if (dn_q.size() == 0) chk("dn_unexpected", 1, 0);
      else begin
        e = dn_q.pop_front();
        chk("dn_address", out_address, e.addr);
        chk("dn_byteenable", out_byteenable, e.be);
        chk("dn_write", out_write, e.wr);
        chk("dn_read", out_read, !e.wr);
        if (e.wr) chk("dn_writedata", out_writedata, e.wd);
      end
    end
  end

  function automatic up_t mk_up(input logic [31:0] d, input logic [1:0] r);
    up_t u; u.rdata = d; u.resp = r; return u;
  endfunction

  function automatic dn_t mk_dn(input logic [7:0] a, input logic [3:0] b,
                                input logic [31:0] w, input logic wr);
    dn_t d; d.addr = a; d.be = b; d.wd = w; d.wr = wr; return d;
  endfunction

  // Latency counts negedges from request drive up to and including completion.
  task automatic xfer(input string nm, input logic [31:0] a, input logic rd, input logic wr,
                      input logic [3:0] be, input logic [31:0] wd,
                      input int exp_lat, input int exp_oreq);
    int  n = 0;
    int  start;
    bit  done = 0;
    start         = oreq_total;
    in_address    = a;
    in_read       = rd;
    in_write      = wr;
    in_byteenable = be;
    in_writedata  = wd;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (!in_waitrequest) done = 1;
    end
    if (!done) chk({nm, "_completion_timeout"}, 0, 1);
    else begin
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_out_req_cycles"}, oreq_total - start, exp_oreq);
    end
    @(posedge clk);
    #1;
    in_read  = 1'b0;
    in_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_address = '0; in_byteenable = '0; in_read = 1'b0; in_write = 1'b0;
    in_writedata = '0; out_readdata = '0; out_response = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_waitrequest", in_waitrequest, 1);
    chk("rst_in_readdata", in_readdata, 0);
    chk("rst_in_response", in_response, 0);
    chk("rst_out_req", {out_read, out_write}, 0);
    chk("rst_out_address", out_address, 0);
    chk("rst_out_byteenable", out_byteenable, 0);
    chk("rst_out_writedata", out_writedata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_readdata = 32'hDEADBEEF; slv_wait = 0;
    dn_q.push_back(mk_dn(8'h04, 4'hF, 32'h0, 1'b0));
    up_q.push_back(mk_up(32'hDEADBEEF, 2'b00));
    xfer("rd_aligned", 32'h0000_0010, 1, 0, 4'hF, 32'h0, 3, 1);
    chk("readdata_hold", in_readdata, 32'hDEADBEEF);

    slv_wait = 3;
    dn_q.push_back(mk_dn(8'h48, 4'hF, 32'h1234_5678, 1'b1));
    up_q.push_back(mk_up(32'h0, 2'b00));
    xfer("wr_wait3", 32'h0000_0120, 0, 1, 4'hF, 32'h1234_5678, 6, 4);
    slv_wait = 0;

    up_q.push_back(mk_up(32'h0, 2'b10));
    xfer("rd_misaligned", 32'h0000_0006, 1, 0, 4'hF, 32'h0, 2, 0);

    up_q.push_back(mk_up(32'h0, 2'b10));
    xfer("rd_and_wr", 32'h0000_0030, 1, 1, 4'hF, 32'h55AA_55AA, 2, 0);

    up_q.push_back(mk_up(32'h0, 2'b11));
    xfer("rd_out_of_range", 32'h0000_0400, 1, 0, 4'hF, 32'h0, 2, 0);

    out_readdata = 32'h0000_A5A5;
    dn_q.push_back(mk_dn(8'hFF, 4'hF, 32'h0, 1'b0));
    up_q.push_back(mk_up(32'h0000_A5A5, 2'b00));
    xfer("rd_top_word", 32'h0000_03FC, 1, 0, 4'hF, 32'h0, 3, 1);

    out_readdata = 32'hCAFE_0001; out_response = 2'b10;
    dn_q.push_back(mk_dn(8'h08, 4'h3, 32'h0, 1'b0));
    up_q.push_back(mk_up(32'hCAFE_0001, 2'b10));
    xfer("rd_slave_err", 32'h0000_0020, 1, 0, 4'h3, 32'h0, 3, 1);
    out_response = 2'b00;

    dn_q.push_back(mk_dn(8'h02, 4'h0, 32'h0BAD_F00D, 1'b1));
    up_q.push_back(mk_up(32'h0, 2'b00));
    xfer("wr_be_zero", 32'h0000_0008, 0, 1, 4'h0, 32'h0BAD_F00D, 3, 1);

    slv_stuck = 1'b1;
    up_q.push_back(mk_up(32'h0, 2'b11));
    xfer("rd_timeout", 32'h0000_0040, 1, 0, 4'hF, 32'h0, 18, 16);
    slv_stuck = 1'b0;

    out_readdata = 32'h1111_2222;
    dn_q.push_back(mk_dn(8'h11, 4'hF, 32'h0, 1'b0));
    up_q.push_back(mk_up(32'h1111_2222, 2'b00));
    xfer("rd_after_timeout", 32'h0000_0044, 1, 0, 4'hF, 32'h0, 3, 1);

    // Reset in the middle of a stalled access: nothing completes upstream.
    slv_stuck = 1'b1;
    in_address = 32'h0000_0050; in_byteenable = 4'hF; in_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_out_read", out_read, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_read", out_read, 0);
    chk("mid_rst_in_waitrequest", in_waitrequest, 1);
    chk("mid_rst_in_readdata", in_readdata, 0);
    in_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; slv_stuck = 1'b0;
    @(posedge clk); #1;

    out_readdata = 32'h7777_8888;
    dn_q.push_back(mk_dn(8'h15, 4'hF, 32'h0, 1'b0));
    up_q.push_back(mk_up(32'h7777_8888, 2'b00));
    xfer("rd_after_reset", 32'h0000_0054, 1, 0, 4'hF, 32'h0, 3, 1);

    repeat (2) @(posedge clk);
    chk("up_queue_drained", up_q.size(), 0);
    chk("dn_queue_drained", dn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
